mem_arbiter: RTL and testbench

//   Shares the single DP_mem32x64k port between instruction fetch (IF) and data

---
 rtl/mem_arbiter.sv | 60 ++++++
 tb/tb_mem_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and data ports.
// Data wins by default; fetch is forced in after STARVE_LIMIT consecutive data grants.
module mem_arbiter #(
  parameter int WORD         = 32,
  parameter int ADDR         = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [ADDR-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [WORD-1:0] if_rdata,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [ADDR-1:0] dm_addr,
  input  logic [WORD-1:0] dm_wdata,
  output logic            dm_gnt,
  output logic            dm_rvalid,
  output logic [WORD-1:0] dm_rdata,
  output logic [ADDR-1:0] mem_A,
  output logic            mem_W,
  output logic [WORD-1:0] mem_D,
  input  logic [WORD-1:0] mem_Q
);
  localparam int CW = STARVE_LIMIT > 0 ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  typedef enum logic [1:0] {RSP_NONE, RSP_IF, RSP_DM} rsp_e;
  rsp_e          rsp_sel_q, rsp_sel_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          force_if;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_sel_q    <= RSP_NONE;
      starve_cnt_q <= '0;
    end else begin
      rsp_sel_q    <= rsp_sel_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end
  // grants are gated by reset so every output is quiet while reset is held
  always_comb begin
    force_if     = (starve_cnt_q == LIM) && if_req;
    dm_gnt       = reset && dm_req && !force_if;
    if_gnt       = reset && if_req && !dm_gnt;
    mem_A        = dm_gnt ? dm_addr : if_gnt ? if_addr : '0;
    mem_W        = dm_gnt && dm_we;
    mem_D        = dm_gnt ? dm_wdata : '0;
    rsp_sel_d    = dm_gnt ? (dm_we ? RSP_NONE : RSP_DM) : if_gnt ? RSP_IF : RSP_NONE;
    starve_cnt_d = (!if_req || if_gnt) ? '0 :
                   (dm_gnt && starve_cnt_q != LIM) ? starve_cnt_q + CW'(1) : starve_cnt_q;
  end
  always_comb begin
    if_rvalid = rsp_sel_q == RSP_IF;
    dm_rvalid = rsp_sel_q == RSP_DM;
    if_rdata  = if_rvalid ? mem_Q : '0;
    dm_rdata  = dm_rvalid ? mem_Q : '0;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, routing, starvation guard and reset.
module tb_mem_arbiter;
  logic        clk = 0, reset = 0;
  logic        if_req = 0, dm_req = 0, dm_we = 0;
  logic [15:0] if_addr = 0, dm_addr = 0;
  logic [31:0] dm_wdata = 0;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_W;
  logic [31:0] if_rdata, dm_rdata, mem_D, mem_Q;
  logic [15:0] mem_A;
  logic [31:0] mem [0:65535];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_A(mem_A), .mem_W(mem_W), .mem_D(mem_D), .mem_Q(mem_Q)
  );

  // write-first synchronous single-port memory
  always @(posedge clk) begin
    if (mem_W) mem[mem_A] <= mem_D;
    mem_Q <= mem_W ? mem_D : mem[mem_A];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 0; if_req = 1; dm_req = 1; dm_we = 1; if_addr = 16'h1234; dm_addr = 16'h5678; dm_wdata = 32'h1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (if_gnt !== 1'b0) begin failures++; $display("FAIL reset_if_gnt got=%b exp=0", if_gnt); end
      checks++; if (dm_gnt !== 1'b0) begin failures++; $display("FAIL reset_dm_gnt got=%b exp=0", dm_gnt); end
      checks++; if (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b%b exp=00", if_rvalid, dm_rvalid); end
      checks++; if (mem_W !== 1'b0 || mem_A !== 16'h0) begin failures++; $display("FAIL reset_mem got W=%b A=%h exp W=0 A=0000", mem_W, mem_A); end
      tick;
    end
    if_req = 0; dm_req = 0; dm_we = 0; reset = 1;
    tick;
  endtask

  task automatic test_if_only;
    for (int a = 0; a < 11; a++) begin
      if_req = a < 10; if_addr = 16'(a);
      #1;
      if (a < 10) begin
        checks++; if (if_gnt !== 1'b1) begin failures++; $display("FAIL if_only_gnt a=%0d got=%b exp=1", a, if_gnt); end
        checks++; if (mem_A !== 16'(a) || mem_W !== 1'b0) begin failures++; $display("FAIL if_only_mem a=%0d got A=%h W=%b exp A=%h W=0", a, mem_A, mem_W, 16'(a)); end
      end
      if (a > 0) begin
        checks++; if (if_rvalid !== 1'b1) begin failures++; $display("FAIL if_only_rvalid a=%0d got=%b exp=1", a - 1, if_rvalid); end
        checks++; if (if_rdata !== {16'hC0DE, 16'(a - 1)}) begin failures++; $display("FAIL if_only_rdata a=%0d got=%h exp=%h", a - 1, if_rdata, {16'hC0DE, 16'(a - 1)}); end
        checks++; if (dm_rvalid !== 1'b0) begin failures++; $display("FAIL if_only_dm_rvalid got=%b exp=0", dm_rvalid); end
      end
      tick;
    end
    if_req = 0;
  endtask

  task automatic test_store_load;
    dm_req = 1; dm_we = 1; dm_addr = 16'h0010; dm_wdata = 32'hDEADBEEF;
    #1;
    checks++; if (dm_gnt !== 1'b1 || mem_W !== 1'b1) begin failures++; $display("FAIL store_gnt got gnt=%b W=%b exp 1 1", dm_gnt, mem_W); end
    checks++; if (mem_A !== 16'h0010 || mem_D !== 32'hDEADBEEF) begin failures++; $display("FAIL store_mem got A=%h D=%h exp 0010 deadbeef", mem_A, mem_D); end
    tick;
    dm_we = 0; dm_wdata = 0;
    #1;
    checks++; if (dm_gnt !== 1'b1 || mem_W !== 1'b0) begin failures++; $display("FAIL load_gnt got gnt=%b W=%b exp 1 0", dm_gnt, mem_W); end
    checks++; if (dm_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin failures++; $display("FAIL store_no_rvalid got dm=%b if=%b exp 0 0", dm_rvalid, if_rvalid); end
    tick;
    dm_req = 0;
    #1;
    checks++; if (dm_rvalid !== 1'b1) begin failures++; $display("FAIL load_rvalid got=%b exp=1", dm_rvalid); end
    checks++; if (dm_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL load_rdata got=%h exp=deadbeef", dm_rdata); end
    checks++; if (mem_W !== 1'b0 || mem_A !== 16'h0) begin failures++; $display("FAIL load_idle_mem got W=%b A=%h exp 0 0000", mem_W, mem_A); end
    tick;
    checks++; if (dm_rvalid !== 1'b0 || dm_rdata !== 32'h0) begin failures++; $display("FAIL load_rvalid_drop got=%b %h exp 0 0", dm_rvalid, dm_rdata); end
  endtask

  task automatic test_contention;
    logic [11:0] exp_if = 12'b0010_0001_0000;
    if_req = 1; dm_req = 1; dm_we = 0; if_addr = 16'h0005; dm_addr = 16'h0007;
    for (int i = 0; i < 13; i++) begin
      if (i == 12) begin if_req = 0; dm_req = 0; end
      #1;
      if (i < 12) begin
        checks++; if (if_gnt !== exp_if[i] || dm_gnt !== !exp_if[i]) begin failures++; $display("FAIL contention_gnt i=%0d got if=%b dm=%b exp if=%b", i, if_gnt, dm_gnt, exp_if[i]); end
      end
      if (i > 0) begin
        checks++; if (if_rvalid !== exp_if[i-1] || dm_rvalid !== !exp_if[i-1]) begin failures++; $display("FAIL contention_route i=%0d got if=%b dm=%b exp if=%b", i - 1, if_rvalid, dm_rvalid, exp_if[i-1]); end
        checks++; if ((exp_if[i-1] ? if_rdata : dm_rdata) !== (exp_if[i-1] ? 32'hC0DE0005 : 32'hC0DE0007)) begin failures++; $display("FAIL contention_rdata i=%0d got if=%h dm=%h", i - 1, if_rdata, dm_rdata); end
      end
      tick;
    end
  endtask

  task automatic test_reset_mid;
    dm_req = 1; dm_we = 0; dm_addr = 16'h0003;
    #1;
    checks++; if (dm_gnt !== 1'b1) begin failures++; $display("FAIL midreset_gnt got=%b exp=1", dm_gnt); end
    @(negedge clk);
    reset = 0;
    #1;
    checks++; if (dm_gnt !== 1'b0) begin failures++; $display("FAIL midreset_gnt_drop got=%b exp=0", dm_gnt); end
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if (dm_rvalid !== 1'b0) begin failures++; $display("FAIL midreset_rvalid i=%0d got=%b exp=0", i, dm_rvalid); end
    end
    dm_req = 0; if_req = 1; if_addr = 16'h0008; reset = 1;
    #1;
    checks++; if (if_gnt !== 1'b1 || dm_rvalid !== 1'b0) begin failures++; $display("FAIL midreset_release got gnt=%b dm_rvalid=%b exp 1 0", if_gnt, dm_rvalid); end
    tick;
    if_req = 0;
    #1;
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hC0DE0008) begin failures++; $display("FAIL midreset_if_return got=%b %h exp 1 c0de0008", if_rvalid, if_rdata); end
    checks++; if (dm_rvalid !== 1'b0) begin failures++; $display("FAIL midreset_dm_quiet got=%b exp=0", dm_rvalid); end
    tick;
  endtask

  task automatic test_idle_gaps;
    logic [9:0] req    = 10'b0111110111;
    logic [9:0] exp_if = 10'b0100000000;
    logic [9:0] exp_dm = 10'b0011110111;
    logic [9:0] we     = 10'b1000001000;
    logic [15:0] ea;
    if_addr = 16'h0021; dm_addr = 16'h0042; dm_wdata = 32'h55AA55AA;
    for (int i = 0; i < 10; i++) begin
      if_req = req[i]; dm_req = req[i]; dm_we = we[i];
      ea = exp_dm[i] ? 16'h0042 : exp_if[i] ? 16'h0021 : 16'h0000;
      #1;
      checks++; if (if_gnt !== exp_if[i] || dm_gnt !== exp_dm[i]) begin failures++; $display("FAIL idle_gnt i=%0d got if=%b dm=%b exp if=%b dm=%b", i, if_gnt, dm_gnt, exp_if[i], exp_dm[i]); end
      checks++; if (mem_A !== ea || mem_W !== 1'b0) begin failures++; $display("FAIL idle_mem i=%0d got A=%h W=%b exp A=%h W=0", i, mem_A, mem_W, ea); end
      tick;
    end
    if_req = 0; dm_req = 0; dm_we = 0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = {16'hC0DE, 16'(i)};
    #1;
    test_reset;
    test_if_only;
    test_store_load;
    test_contention;
    test_reset_mid;
    test_idle_gaps;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
